// File: rtl/sample_sequencer.sv
// Master-side request sequencer for the outlier detector: times new_number pulses,
// captures {flag, x} into a first-word-fall-through FIFO and counts outliers per run.
module sample_sequencer #(
    parameter int DATA_W     = 32,
    parameter int HIGH_CYC   = 20,
    parameter int SETTLE_CYC = 8,
    parameter int GAP_CYC    = 51,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       count,
    output logic              new_number,
    input  logic [DATA_W-1:0] x_in,
    input  logic              flag_in,
    input  logic              rd_en,
    output logic [DATA_W:0]   rd_data,
    output logic              empty,
    output logic              full,
    output logic              busy,
    output logic              done,
    output logic [15:0]       outlier_cnt,
    output logic              overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = 16;

    typedef enum logic [2:0] {IDLE, PULSE, SETTLE, CAPTURE, GAP} state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic [15:0]     remaining;

    logic [DATA_W:0] mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   rd_nxt;
    logic [AW:0]     occ;
    logic            capture;
    logic            do_pop;
    logic            do_push;
    logic [DATA_W:0] din;

    assign capture = (state == CAPTURE);
    assign din     = {flag_in, x_in};
    assign empty   = (occ == '0);
    assign full    = (occ == (AW+1)'(FIFO_DEPTH));
    assign do_pop  = rd_en && !empty;
    // A pop in the capture cycle frees a slot, so a full FIFO still accepts the sample.
    assign do_push = capture && (!full || do_pop);
    assign rd_nxt  = rd_ptr + 1'b1;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            remaining   <= '0;
            new_number  <= 1'b0;
            done        <= 1'b0;
            outlier_cnt <= '0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            remaining   <= count;
                            outlier_cnt <= '0;
                            overflow    <= 1'b0;
                            new_number  <= 1'b1;
                            timer       <= TW'(HIGH_CYC - 1);
                            state       <= PULSE;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                PULSE: begin
                    if (timer == '0) begin
                        new_number <= 1'b0;
                        timer      <= TW'(SETTLE_CYC - 1);
                        state      <= SETTLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                SETTLE: begin
                    if (timer == '0) begin
                        state <= CAPTURE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                CAPTURE: begin
                    if (!do_push) begin
                        overflow <= 1'b1;
                    end
                    if (flag_in && (outlier_cnt != '1)) begin
                        outlier_cnt <= outlier_cnt + 1'b1;
                    end
                    remaining <= remaining - 1'b1;
                    if (remaining == 16'd1) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        timer <= TW'(GAP_CYC - 1);
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (timer == '0) begin
                        new_number <= 1'b1;
                        timer      <= TW'(HIGH_CYC - 1);
                        state      <= PULSE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // rd_data is a register tracking the head, so it keeps the last popped word when empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            rd_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_nxt;
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            if (do_pop) begin
                if (occ != (AW+1)'(1)) begin
                    rd_data <= mem[rd_nxt];
                end else if (do_push) begin
                    rd_data <= din;
                end
            end else if (do_push && empty) begin
                rd_data <= din;
            end
        end
    end

endmodule
